// File: rtl/seg7_time_scanner_if.sv
// BCD time bus from the clock core to the display scanner.
// The clock core drives the bus (master); the scanner only reads it (slave).
interface seg7_time_scanner_if;
  logic       tick_1Hz;
  logic [3:0] sec_1s;
  logic [3:0] sec_10s;
  logic [3:0] min_1s;
  logic [3:0] min_10s;
  logic [3:0] hr_1s;
  logic [3:0] hr_10s;

  modport master (
    output tick_1Hz, sec_1s, sec_10s, min_1s, min_10s, hr_1s, hr_10s
  );

  modport slave (
    input tick_1Hz, sec_1s, sec_10s, min_1s, min_10s, hr_1s, hr_10s
  );
endinterface

// File: rtl/seg7_time_scanner.sv
// Four-digit common-anode 7-segment scanner for HH:MM / MM:SS time display.
// Features: frame-coherent snapshots, hour leading-zero blanking, blinking colon, 8-level PWM.
module seg7_time_scanner #(
  parameter int DIGIT_CYCLES = 100_000
) (
  input  logic                 clk_100MHz,
  input  logic                 reset_n,
  seg7_time_scanner_if.slave   time_bus,
  input  logic                 show_sec,
  input  logic [2:0]           bright,
  output logic [6:0]           seg,
  output logic                 dp,
  output logic [3:0]           an
);

  localparam int CW = $clog2(DIGIT_CYCLES);
  localparam logic [CW-1:0] SLOT_LAST = CW'(DIGIT_CYCLES - 1);
  localparam logic [CW-1:0] PWM_STEP  = CW'(DIGIT_CYCLES / 8);

  logic [CW-1:0] slot_ctr_reg;
  logic [1:0]    idx_reg;
  logic [3:0]    digit_reg [4];
  logic          sec_mode_reg;
  logic          load_pending_reg;
  logic [3:0]    an_reg;
  logic [6:0]    seg_reg;
  logic          dp_reg;

  logic [3:0]    live_digit [4];
  logic          slot_wrap;
  logic          snap_load;
  logic [3:0]    cur_digit;
  logic          cur_sec_mode;
  logic [CW-1:0] pwm_level;
  logic          digit_on;
  logic [3:0]    an_next;
  logic [6:0]    seg_next;
  logic          dp_next;

  always_comb begin
    if (show_sec) begin
      live_digit[3] = time_bus.min_10s;
      live_digit[2] = time_bus.min_1s;
      live_digit[1] = time_bus.sec_10s;
      live_digit[0] = time_bus.sec_1s;
    end else begin
      live_digit[3] = time_bus.hr_10s;
      live_digit[2] = time_bus.hr_1s;
      live_digit[1] = time_bus.min_10s;
      live_digit[0] = time_bus.min_1s;
    end
  end

  assign slot_wrap = (slot_ctr_reg == SLOT_LAST);
  assign snap_load = load_pending_reg || (slot_wrap && (idx_reg == 2'd3));

  always_ff @(posedge clk_100MHz) begin
    if (!reset_n) begin
      slot_ctr_reg     <= '0;
      idx_reg          <= 2'd0;
      sec_mode_reg     <= 1'b0;
      load_pending_reg <= 1'b1;
    end else begin
      slot_ctr_reg <= slot_wrap ? '0 : slot_ctr_reg + CW'(1);
      if (slot_wrap) begin
        idx_reg <= idx_reg + 2'd1;
      end
      if (snap_load) begin
        sec_mode_reg     <= show_sec;
        load_pending_reg <= 1'b0;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_digit
      always_ff @(posedge clk_100MHz) begin
        if (!reset_n) begin
          digit_reg[gi] <= 4'd0;
        end else if (snap_load) begin
          digit_reg[gi] <= live_digit[gi];
        end
      end
      assign an_next[gi] = ~(digit_on && (idx_reg == 2'(gi)));
    end
  endgenerate

  // The first slot after reset shows the snapshot being loaded right now,
  // so the display never flashes the cleared digits.
  assign cur_digit    = load_pending_reg ? live_digit[idx_reg] : digit_reg[idx_reg];
  assign cur_sec_mode = load_pending_reg ? show_sec : sec_mode_reg;
  assign pwm_level    = slot_ctr_reg / PWM_STEP;
  assign digit_on     = (pwm_level <= CW'(bright)) &&
                        !((idx_reg == 2'd3) && !cur_sec_mode && (cur_digit == 4'd0));

  always_comb begin
    seg_next = 7'b1111111;
    if (digit_on) begin
      case (cur_digit)
        4'd0:    seg_next = 7'b1000000;
        4'd1:    seg_next = 7'b1111001;
        4'd2:    seg_next = 7'b0100100;
        4'd3:    seg_next = 7'b0110000;
        4'd4:    seg_next = 7'b0011001;
        4'd5:    seg_next = 7'b0010010;
        4'd6:    seg_next = 7'b0000010;
        4'd7:    seg_next = 7'b1111000;
        4'd8:    seg_next = 7'b0000000;
        4'd9:    seg_next = 7'b0010000;
        default: seg_next = 7'b0111111;
      endcase
    end
  end

  assign dp_next = ~(digit_on && (idx_reg == 2'd2) && (cur_sec_mode || time_bus.tick_1Hz));

  always_ff @(posedge clk_100MHz) begin
    if (!reset_n) begin
      an_reg  <= 4'b1111;
      seg_reg <= 7'b1111111;
      dp_reg  <= 1'b1;
    end else begin
      an_reg  <= an_next;
      seg_reg <= seg_next;
      dp_reg  <= dp_next;
    end
  end

  assign an  = an_reg;
  assign seg = seg_reg;
  assign dp  = dp_reg;

endmodule
